rv_data_mem: RTL and testbench

Parametrised single-clock data memory for the RISC-V core, replacing the fixed 4-word memory block. It has one load/store port with a valid/ready request handshake and RISC-V funct3 sizing: byte and halfword lanes, sign or zero extension, and misalignment detection. It also has an independent read-only fetch port. After every reset, a hardware init sequencer zero-fills the array before any request is accepted.

---
 rtl/rv_data_mem_if.sv | 29 ++
 rtl/rv_data_mem.sv | 142 ++++++++++++++
 tb/tb_rv_data_mem.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rv_data_mem_if.sv
// rtl/rv_data_mem_if.sv - load/store, response and fetch signals of rv_data_mem
interface rv_data_mem_if #(
    parameter int MEM_DEPTH = 256
);
    localparam int AW = $clog2(MEM_DEPTH) + 2;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          init_done;

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, if_addr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, if_rdata, init_done
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, if_addr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, if_rdata, init_done
    );
endinterface

// File: rtl/rv_data_mem.sv
// rtl/rv_data_mem.sv - data memory with sized load/store port, fetch port and zero-fill init
module rv_data_mem #(
    parameter int MEM_DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst,
    rv_data_mem_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH) + 2;
    localparam int IW = AW - 2;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        r_state;
    logic [IW-1:0] r_cnt;
    logic          r_init_done;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_mem [MEM_DEPTH];

    logic          w_accept;
    logic          w_err;
    logic          w_store;
    logic [IW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wlane;

    assign w_accept = bus.req_valid && (r_state == S_RUN);
    assign w_idx    = bus.req_addr[AW-1:2];
    assign w_off    = bus.req_addr[1:0];
    assign w_word   = r_mem[w_idx];
    assign w_store  = w_accept && bus.req_we && !w_err;

    always_comb begin
        w_err = 1'b1;
        case (bus.req_size)
            3'b000: w_err = 1'b0;
            3'b001: w_err = w_off[0];
            3'b010: w_err = |w_off;
            3'b100: w_err = bus.req_we;
            3'b101: w_err = bus.req_we | w_off[0];
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (w_off)
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
        w_load = 32'h0;
        case (bus.req_size)
            3'b000: w_load = {{24{w_byte[7]}}, w_byte};
            3'b100: w_load = {24'h0, w_byte};
            3'b001: w_load = {{16{w_half[15]}}, w_half};
            3'b101: w_load = {16'h0, w_half};
            3'b010: w_load = w_word;
            default: w_load = 32'h0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target lane.
    always_comb begin
        w_be    = 4'b0000;
        w_wlane = 32'h0;
        case (bus.req_size)
            3'b000: begin
                w_be    = 4'b0001 << w_off;
                w_wlane = {4{bus.req_wdata[7:0]}};
            end
            3'b001: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{bus.req_wdata[15:0]}};
            end
            3'b010: begin
                w_be    = 4'b1111;
                w_wlane = bus.req_wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wlane = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_cnt] <= 32'h0;
        end else if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_if_rdata  <= 32'h0;
        end else begin
            r_if_rdata <= r_mem[bus.if_addr[AW-1:2]];
            case (r_state)
                S_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == IW'(MEM_DEPTH - 1)) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                S_RUN: r_state <= S_RUN;
                default: r_state <= S_INIT;
            endcase
            r_rsp_valid <= w_accept;
            r_rsp_err   <= w_accept && w_err;
            r_rsp_rdata <= (w_accept && !w_err && !bus.req_we) ? w_load : 32'h0;
        end
    end

    assign bus.req_ready = (r_state == S_RUN);
    assign bus.init_done = r_init_done;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.if_rdata  = r_if_rdata;
endmodule

// File: tb/tb_rv_data_mem.sv
// tb/tb_rv_data_mem.sv - directed vector bench for rv_data_mem with MEM_DEPTH=16
module tb_rv_data_mem;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    rv_data_mem_if #(.MEM_DEPTH(DEPTH)) bus ();

    rv_data_mem #(.MEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [5:0]  addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input logic we, input logic [5:0] addr,
                                input logic [2:0] size, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.size = size;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic we, input logic [5:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_wdata = wdata;
    endtask

    task automatic do_req(input string name, input logic we, input logic [5:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        drive(we, addr, size, wdata);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk({name, ".valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({name, ".rdata"}, bus.rsp_rdata, exp_rdata);
        chk({name, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
        @(posedge clk); #1;
        chk({name, ".pulse"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!bus.req_ready && n < 40) begin
            @(posedge clk); #1;
            chk({name, ".no_rsp"}, 32'(bus.rsp_valid), 32'd0);
            n++;
        end
        chk({name, ".init_cycles"}, 32'(n), 32'(DEPTH));
        chk({name, ".init_done"}, 32'(bus.init_done), 32'd1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = 3'b010;
        bus.req_wdata = '0;
        bus.if_addr   = '0;

        #12;
        chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst.init_done", 32'(bus.init_done), 32'd0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst.if_rdata", bus.if_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_init("init1");
        do_req("lw_after_init", 1'b0, 6'h24, 3'b010, 32'h0, 32'h0, 1'b0);

        add("sw_8",      1, 6'h08, 3'b010, 32'hDEADBEEF, 32'h0,        0);
        add("sb_9",      1, 6'h09, 3'b000, 32'hFFFFFF5A, 32'h0,        0);
        add("lw_8",      0, 6'h08, 3'b010, 32'h0,        32'hDEAD5AEF, 0);
        add("lb_9",      0, 6'h09, 3'b000, 32'h0,        32'h0000005A, 0);
        add("lh_a",      0, 6'h0A, 3'b001, 32'h0,        32'hFFFFDEAD, 0);
        add("lhu_a",     0, 6'h0A, 3'b101, 32'h0,        32'h0000DEAD, 0);
        add("lb_8",      0, 6'h08, 3'b000, 32'h0,        32'hFFFFFFEF, 0);
        add("lbu_8",     0, 6'h08, 3'b100, 32'h0,        32'h000000EF, 0);
        add("lbu_b",     0, 6'h0B, 3'b100, 32'h0,        32'h000000DE, 0);
        add("lw_6_mis",  0, 6'h06, 3'b010, 32'h0,        32'h0,        1);
        add("sh_3_mis",  1, 6'h03, 3'b001, 32'hFFFF,     32'h0,        1);
        add("f3_011",    0, 6'h04, 3'b011, 32'h0,        32'h0,        1);
        add("sbu_store", 1, 6'h04, 3'b100, 32'hFF,       32'h0,        1);
        add("sw_f3_111", 1, 6'h04, 3'b111, 32'hFFFFFFFF, 32'h0,        1);
        add("lw_4_same", 0, 6'h04, 3'b010, 32'h0,        32'h0,        0);
        add("sh_e",      1, 6'h0E, 3'b001, 32'hABCD9234, 32'h0,        0);
        add("lw_c",      0, 6'h0C, 3'b010, 32'h0,        32'h92340000, 0);
        add("lh_e",      0, 6'h0E, 3'b001, 32'h0,        32'hFFFF9234, 0);
        add("lhu_c",     0, 6'h0C, 3'b101, 32'h0,        32'h00000000, 0);
        add("lh_d_mis",  0, 6'h0D, 3'b001, 32'h0,        32'h0,        1);
        add("lw_3c",     0, 6'h3C, 3'b010, 32'h0,        32'h0,        0);

        foreach (vecs[i])
            do_req(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err);

        drive(1'b1, 6'h00, 3'b010, 32'h11223344);
        @(posedge clk); #1;
        chk("b2b.sw_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b.sw_rdata", bus.rsp_rdata, 32'h0);
        drive(1'b0, 6'h00, 3'b010, 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("b2b.lw_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b.lw_rdata", bus.rsp_rdata, 32'h11223344);
        @(posedge clk); #1;
        chk("b2b.idle", 32'(bus.rsp_valid), 32'd0);

        bus.if_addr = 6'h01;
        @(posedge clk); #1;
        chk("fetch.pre", bus.if_rdata, 32'h11223344);
        drive(1'b1, 6'h00, 3'b010, 32'hCAFEF00D);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("fetch.old", bus.if_rdata, 32'h11223344);
        @(posedge clk); #1;
        chk("fetch.new", bus.if_rdata, 32'hCAFEF00D);

        rst = 1'b0;
        #2;
        chk("rst2.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst2.if_rdata", bus.if_rdata, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 6'h00, 3'b010, 32'h0);
        rst = 1'b1;
        wait_init("init2");
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("held.valid", 32'(bus.rsp_valid), 32'd1);
        chk("held.cleared", bus.rsp_rdata, 32'h0);
        @(posedge clk); #1;

        drive(1'b1, 6'h10, 3'b010, 32'h55AA55AA);
        @(posedge clk); #2;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("drop.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("drop.ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("drop.still0", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b1;
        wait_init("init3");
        do_req("lw_10_cleared", 1'b0, 6'h10, 3'b010, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
